apb_master_bridge: RTL

- Single-outstanding APB requester that sits directly upstream of the APB memory slave.
- Accepts simple read/write requests on a valid/ready port and drives the APB IDLE→SETUP→ACCESS sequence on Paddr/Pselx/Penable/Pwrite/Pwdata.
- Waits on Pready, captures Prdata/Pslverr, and returns a one-cycle response pulse.
- A wait-state timeout guards against a slave that never asserts Pready.

---
 rtl/apb_pkg.sv | 19 +
 rtl/apb_master_bridge_if.sv | 39 +++
 rtl/apb_wait_timer.sv | 37 +++
 rtl/apb_master_bridge.sv | 129 ++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared APB types and default widths
package apb_pkg;

  localparam int APB_ADDR_W = 5;
  localparam int APB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETUP  = 2'b01,
    ACCESS = 2'b10
  } apb_state_e;

  typedef struct packed {
    logic [APB_DATA_W-1:0] rdata;
    logic                  err;
    logic                  timeout;
  } apb_rsp_t;

endpackage

// File: rtl/apb_master_bridge_if.sv
// rtl/apb_master_bridge_if.sv - request/response port and APB bus bundle
interface apb_master_bridge_if
  import apb_pkg::*;
#(
  parameter int ADDR_W = APB_ADDR_W,
  parameter int DATA_W = APB_DATA_W
);

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rsp_timeout;
  logic [ADDR_W-1:0] Paddr;
  logic              Pselx;
  logic              Penable;
  logic              Pwrite;
  logic [DATA_W-1:0] Pwdata;
  logic              Pready;
  logic              Pslverr;
  logic [DATA_W-1:0] Prdata;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, Pready, Pslverr, Prdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output Paddr, Pselx, Penable, Pwrite, Pwdata
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, Pready, Pslverr, Prdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  Paddr, Pselx, Penable, Pwrite, Pwdata
  );

endinterface

// File: rtl/apb_wait_timer.sv
// rtl/apb_wait_timer.sv - saturating ACCESS wait-state counter with expiry flag
module apb_wait_timer #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYC);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Fires on the waiting edge that would bring the count up to TIMEOUT_CYC.
  assign expire = (TIMEOUT_CYC != 0) && en && (cnt_q >= LIMIT - 1'b1);

endmodule

// File: rtl/apb_master_bridge.sv
// rtl/apb_master_bridge.sv - single-outstanding APB requester with wait-state timeout
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int ADDR_W      = APB_ADDR_W,
  parameter int DATA_W      = APB_DATA_W,
  parameter int TIMEOUT_CYC = 16
) (
  input logic                 Pclk,
  input logic                 Prst,
  apb_master_bridge_if.master bus
);

  apb_state_e        state_q, state_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic              pwrite_q, pwrite_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              rsp_timeout_q, rsp_timeout_d;
  logic              timer_clr, timer_en, timer_expire;

  apb_wait_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_wait_timer (
    .clk    (Pclk),
    .rst    (Prst),
    .clr    (timer_clr),
    .en     (timer_en),
    .expire (timer_expire)
  );

  always_comb begin
    state_d       = state_q;
    paddr_d       = paddr_q;
    pwrite_d      = pwrite_q;
    pwdata_d      = pwdata_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    timer_clr     = 1'b0;
    timer_en      = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          state_d   = SETUP;
          paddr_d   = bus.req_addr;
          pwrite_d  = bus.req_write;
          pwdata_d  = bus.req_write ? bus.req_wdata : '0;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          timer_clr = 1'b1;
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
      end
      ACCESS: begin
        timer_en = !bus.Pready;
        // Pready is checked first so a completion on the expiry edge wins.
        if (bus.Pready) begin
          state_d       = IDLE;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_err_d     = bus.Pslverr;
          rsp_timeout_d = 1'b0;
          rsp_rdata_d   = (!pwrite_q && !bus.Pslverr) ? bus.Prdata : '0;
        end else if (timer_expire) begin
          state_d       = IDLE;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
          rsp_rdata_d   = '0;
        end
      end
      default: begin
        state_d   = IDLE;
        psel_d    = 1'b0;
        penable_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Pclk) begin
    if (Prst) begin
      state_q       <= IDLE;
      paddr_q       <= '0;
      pwrite_q      <= 1'b0;
      pwdata_q      <= '0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      paddr_q       <= paddr_d;
      pwrite_q      <= pwrite_d;
      pwdata_q      <= pwdata_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign bus.req_ready   = (state_q == IDLE);
  assign bus.Paddr       = paddr_q;
  assign bus.Pwrite      = pwrite_q;
  assign bus.Pwdata      = pwdata_q;
  assign bus.Pselx       = psel_q;
  assign bus.Penable     = penable_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.rsp_timeout = rsp_timeout_q;

endmodule
